// File: rtl/fpadd_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : fpadd_rr_scheduler_if
// Description : Request/response bundle between requesters and the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpadd_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/fpadd_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fpadd_rr_scheduler
// Description : Round-robin sharing of one multi-cycle FP32 adder, with watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module fpadd_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 127
) (
  input  wire         clk,
  input  wire         rst,
  fpadd_rr_scheduler_if.slave bus,
  output logic        fpa_rst,
  output logic [31:0] fpa_a,
  output logic [31:0] fpa_b,
  input  wire         fpa_done,
  input  wire  [31:0] fpa_out,
  output logic        busy,
  output logic        err_sticky
);

  localparam int                 c_WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] c_ONE     = NUM_REQ'(1);
  localparam logic [31:0]        c_QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [c_WD_W-1:0]   r_wd_cnt;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [31:0]         r_rsp_data;
  logic                r_rsp_err;

  logic                w_any;
  logic                w_hi_any;
  logic [ID_W-1:0]     w_hi_idx;
  logic [ID_W-1:0]     w_lo_idx;
  logic [ID_W-1:0]     w_grant_idx;
  logic [NUM_REQ-1:0]  w_grant;
  logic [31:0]         w_sel_a;
  logic [31:0]         w_sel_b;
  logic                w_timeout;

  // Descending scan leaves the lowest index in each candidate; the "hi" set
  // covers indices at or above rr_ptr, the "lo" set is the wrapped fallback.
  always_comb begin
    w_any    = 1'b0;
    w_hi_any = 1'b0;
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_any    = 1'b1;
        w_lo_idx = ID_W'(i);
        if (ID_W'(i) >= r_rr_ptr) begin
          w_hi_any = 1'b1;
          w_hi_idx = ID_W'(i);
        end
      end
    end
    w_grant_idx = w_hi_any ? w_hi_idx : w_lo_idx;
    w_grant     = w_any ? (c_ONE << w_grant_idx) : '0;
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == ID_W'(i)) begin
        w_sel_a = bus.req_a[32*i +: 32];
        w_sel_b = bus.req_b[32*i +: 32];
      end
    end
  end

  assign w_timeout     = (r_wd_cnt == c_WD_LAST);
  assign bus.req_ready = (r_state == S_IDLE && !rst) ? w_grant : '0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign busy          = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT:   if (fpa_done || w_timeout) w_state_nxt = S_RESP;
      S_RESP:   if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_wd_cnt    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      fpa_rst     <= 1'b1;
      fpa_a       <= '0;
      fpa_b       <= '0;
      err_sticky  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            fpa_a    <= w_sel_a;
            fpa_b    <= w_sel_b;
            r_rsp_id <= w_grant_idx;
            r_rr_ptr <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
          end
        end
        S_LAUNCH: begin
          r_wd_cnt <= '0;
          fpa_rst  <= 1'b0;
        end
        S_WAIT: begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
          // A done arriving on the last watchdog cycle still counts as success.
          if (fpa_done) begin
            r_rsp_data  <= fpa_out;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
          end else if (w_timeout) begin
            r_rsp_data  <= c_QNAN;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            err_sticky  <= 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            fpa_rst     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpadd_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpadd_rr_scheduler
// Description : Directed bench for fpadd_rr_scheduler with a table-driven adder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpadd_rr_scheduler;

  localparam int c_TIMEOUT = 127;

  logic        clk;
  logic        rst;
  logic        fpa_rst;
  logic [31:0] fpa_a;
  logic [31:0] fpa_b;
  logic        fpa_done;
  logic [31:0] fpa_out;
  logic        busy;
  logic        err_sticky;
  logic        hang;
  int          r_mdl_cnt;
  int          n_checks;
  int          n_errors;
  int          n;
  logic [3:0]  g;
  logic        seen;

  logic [31:0] tab_a [4] = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000};
  logic [31:0] tab_b [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000};
  logic [31:0] tab_s [4] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40C0_0000};

  fpadd_rr_scheduler_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  fpadd_rr_scheduler #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(c_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fpa_rst    (fpa_rst),
    .fpa_a      (fpa_a),
    .fpa_b      (fpa_b),
    .fpa_done   (fpa_done),
    .fpa_out    (fpa_out),
    .busy       (busy),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sums only for the hand-picked operand pairs; anything else is flagged as 0xFFFFFFFF.
  function automatic logic [31:0] f_sum(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0) return b;
    if (b[30:0] == 31'd0) return a;
    if (a == {~b[31], b[30:0]}) return 32'h0;
    case ({a, b})
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
      {32'h4000_0000, 32'h4080_0000}: return 32'h40C0_0000;
      default:                        return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic f_fast(input logic [31:0] a, input logic [31:0] b);
    return (a[30:0] == 31'd0) || (b[30:0] == 31'd0) || (a == {~b[31], b[30:0]});
  endfunction

  always_ff @(posedge clk) begin
    if (fpa_rst) r_mdl_cnt <= 0;
    else         r_mdl_cnt <= r_mdl_cnt + 1;
  end

  assign fpa_done = !fpa_rst && !hang && (r_mdl_cnt == (f_fast(fpa_a, fpa_b) ? 2 : 7));
  assign fpa_out  = fpa_done ? f_sum(fpa_a, fpa_b) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  task automatic wait_grant(output logic [3:0] gnt);
    int k;
    k = 0;
    #1;
    while (bus.req_ready == 4'b0 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    gnt = bus.req_ready;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.rsp_valid && cyc < 400);
    chk("rsp_seen", {31'd0, bus.rsp_valid}, 32'd1);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    hang = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_id", {30'd0, bus.rsp_id}, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fpa_rst", {31'd0, fpa_rst}, 32'd1);
    chk("rst_fpa_a", fpa_a, 32'd0);
    chk("rst_fpa_b", fpa_b, 32'd0);
    chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    rst = 1'b0;

    // single requester 1: 1.0 + 2.0
    @(negedge clk);
    set_op(1, 32'h3F80_0000, 32'h4000_0000);
    bus.req_valid = 4'b0010;
    #1;
    chk("t1_grant", {28'd0, bus.req_ready}, 32'b0010);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    chk("t1_grant_once", {28'd0, bus.req_ready}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_rsp(n);
    chk("t1_id", {30'd0, bus.rsp_id}, 32'd1);
    chk("t1_data", bus.rsp_data, 32'h4040_0000);
    chk("t1_err", {31'd0, bus.rsp_err}, 32'd0);

    // all four held valid: order 0,1,2,3,0,1 after a pointer reset
    do_reset;
    for (int i = 0; i < 4; i++) set_op(i, tab_a[i], tab_b[i]);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_grant(g);
      chk("t2_grant", {28'd0, g}, 32'd1 << (k % 4));
      chk("t2_idle_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      if (k == 5) bus.req_valid = 4'b0000;
      #1;
      chk("t2_busy", {31'd0, busy}, 32'd1);
      wait_rsp(n);
      chk("t2_id", {30'd0, bus.rsp_id}, k % 4);
      chk("t2_data", bus.rsp_data, tab_s[k % 4]);
      chk("t2_err", {31'd0, bus.rsp_err}, 32'd0);
    end

    // zero operand on requester 2: minimum latency of 5 cycles
    @(negedge clk);
    set_op(2, 32'h0000_0000, 32'hC0A0_0000);
    bus.req_valid = 4'b0100;
    #1;
    chk("t3_grant", {28'd0, bus.req_ready}, 32'b0100);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 4'b0000;
      #1;
      if (c == 1) chk("t3_launch_fpa_rst", {31'd0, fpa_rst}, 32'd1);
      if (c == 2) begin
        chk("t3_wait_fpa_rst", {31'd0, fpa_rst}, 32'd0);
        chk("t3_fpa_a", fpa_a, 32'h0000_0000);
        chk("t3_fpa_b", fpa_b, 32'hC0A0_0000);
      end
      if (c == 4) chk("t3_not_early", {31'd0, bus.rsp_valid}, 32'd0);
      if (c == 5) begin
        chk("t3_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("t3_data", bus.rsp_data, 32'hC0A0_0000);
        chk("t3_id", {30'd0, bus.rsp_id}, 32'd2);
      end
    end

    // exact cancel on requester 3: 1.0 + -1.0
    @(negedge clk);
    set_op(3, 32'h3F80_0000, 32'hBF80_0000);
    bus.req_valid = 4'b1000;
    #1;
    chk("t3b_grant", {28'd0, bus.req_ready}, 32'b1000);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    wait_rsp(n);
    chk("t3b_latency", n, 32'd4);
    chk("t3b_data", bus.rsp_data, 32'h0);
    chk("t3b_id", {30'd0, bus.rsp_id}, 32'd3);

    // back-pressure with requesters 0 and 3 pending
    @(negedge clk);
    set_op(0, 32'h3F80_0000, 32'h4000_0000);
    set_op(3, 32'h4000_0000, 32'h4080_0000);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1001;
    #1;
    chk("t4_grant0", {28'd0, bus.req_ready}, 32'b0001);
    @(negedge clk);
    bus.req_valid = 4'b1000;
    #1;
    chk("t4_no_grant_launch", {28'd0, bus.req_ready}, 32'd0);
    wait_rsp(n);
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("t4_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("t4_hold_id", {30'd0, bus.rsp_id}, 32'd0);
      chk("t4_hold_data", bus.rsp_data, 32'h4040_0000);
      chk("t4_hold_ready", {28'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("t4_grant3", {28'd0, bus.req_ready}, 32'b1000);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    wait_rsp(n);
    chk("t4_id3", {30'd0, bus.rsp_id}, 32'd3);
    chk("t4_data3", bus.rsp_data, 32'h40C0_0000);

    // hung adder: watchdog response, then a clean op with sticky error kept
    @(negedge clk);
    hang = 1'b1;
    set_op(1, 32'h3F80_0000, 32'h3F80_0000);
    bus.req_valid = 4'b0010;
    #1;
    chk("t5_grant", {28'd0, bus.req_ready}, 32'b0010);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    wait_rsp(n);
    chk("t5_latency", n, c_TIMEOUT + 1);
    chk("t5_data", bus.rsp_data, 32'h7FC0_0000);
    chk("t5_err", {31'd0, bus.rsp_err}, 32'd1);
    chk("t5_sticky", {31'd0, err_sticky}, 32'd1);
    chk("t5_id", {30'd0, bus.rsp_id}, 32'd1);
    @(negedge clk);
    hang = 1'b0;
    set_op(2, 32'h0000_0000, 32'hC0A0_0000);
    bus.req_valid = 4'b0100;
    #1;
    chk("t5_grant2", {28'd0, bus.req_ready}, 32'b0100);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    wait_rsp(n);
    chk("t5_clean_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("t5_sticky_kept", {31'd0, err_sticky}, 32'd1);
    chk("t5_clean_data", bus.rsp_data, 32'hC0A0_0000);

    // asynchronous reset in the middle of WAIT
    @(negedge clk);
    set_op(1, 32'h3F80_0000, 32'h4000_0000);
    bus.req_valid = 4'b0010;
    #1;
    chk("t6_grant", {28'd0, bus.req_ready}, 32'b0010);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t6_wait_busy", {31'd0, busy}, 32'd1);
    chk("t6_wait_fpa_rst", {31'd0, fpa_rst}, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_fpa_rst", {31'd0, fpa_rst}, 32'd1);
    chk("t6_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("t6_rst_fpa_a", fpa_a, 32'd0);
    chk("t6_rst_sticky", {31'd0, err_sticky}, 32'd0);
    chk("t6_rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
    chk("t6_rst_id", {30'd0, bus.rsp_id}, 32'd0);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      seen = seen | bus.rsp_valid;
    end
    chk("t6_no_rsp", {31'd0, seen}, 32'd0);
    set_op(2, 32'h0000_0000, 32'hC0A0_0000);
    bus.req_valid = 4'b0100;
    #1;
    chk("t6_grant2", {28'd0, bus.req_ready}, 32'b0100);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    wait_rsp(n);
    chk("t6_latency", n, 32'd4);
    chk("t6_id", {30'd0, bus.rsp_id}, 32'd2);
    chk("t6_data", bus.rsp_data, 32'hC0A0_0000);
    chk("t6_err", {31'd0, bus.rsp_err}, 32'd0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
